// File: rtl/trigger_pulse_gen.sv
// Trigger-line pulse generator: programmable delay, active width and hold-off, with busy/done handshake.
// Define TRIGGER_PULSE_GEN_BURST_EN to add the burst port (train of N pulses per start).

module trigger_pulse_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             edge_sel,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
`ifdef TRIGGER_PULSE_GEN_BURST_EN
    input  logic [CNT_W-1:0] burst,
`endif
    output logic             out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        ACTIVE  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             pol_q, pol_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] extra_pulses;
    logic             last;
    logic             more;

`ifdef TRIGGER_PULSE_GEN_BURST_EN
    assign extra_pulses = (burst == '0) ? '0 : burst - CNT_W'(1);
`else
    assign extra_pulses = '0;
`endif

    assign last = (cnt_q <= CNT_W'(1));
    assign more = (rem_q != '0);

    // out is driven from the state one edge late, so the final busy cycle is
    // spent in IDLE retiring the operation (done strobe) before start is honoured.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wid_d   = wid_q;
        gap_d   = gap_q;
        rem_d   = rem_q;
        pol_d   = pol_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = ~pol_q;
        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    out_d = ~edge_sel;
                    if (start) begin
                        pol_d  = edge_sel;
                        wid_d  = (width == '0) ? CNT_W'(1) : width;
                        gap_d  = gap;
                        rem_d  = extra_pulses;
                        busy_d = 1'b1;
                        if (delay != '0) begin
                            state_d = DELAY;
                            cnt_d   = delay;
                        end else begin
                            state_d = ACTIVE;
                            cnt_d   = (width == '0) ? CNT_W'(1) : width;
                        end
                    end
                end
            end
            DELAY: begin
                if (last) begin
                    state_d = ACTIVE;
                    cnt_d   = wid_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACTIVE: begin
                out_d = pol_q;
                if (!last) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (gap_q != '0) begin
                    state_d = HOLDOFF;
                    cnt_d   = gap_q;
                end else if (more) begin
                    rem_d = rem_q - CNT_W'(1);
                    cnt_d = wid_q;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HOLDOFF: begin
                if (!last) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (more) begin
                    state_d = ACTIVE;
                    rem_d   = rem_q - CNT_W'(1);
                    cnt_d   = wid_q;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wid_q   <= '0;
            gap_q   <= '0;
            rem_q   <= '0;
            pol_q   <= 1'b1;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wid_q   <= wid_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
            pol_q   <= pol_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Self-checking bench for trigger_pulse_gen: directed cases plus random traffic against an interval-based model.
// Build with TRIGGER_PULSE_GEN_BURST_EN to also exercise pulse trains.

module tb_trigger_pulse_gen;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             edge_sel;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] gap;
    logic [CNT_W-1:0] burst;
    logic             out;
    logic             busy;
    logic             done;

    trigger_pulse_gen #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .edge_sel (edge_sel),
        .delay    (delay),
        .width    (width),
        .gap      (gap),
`ifdef TRIGGER_PULSE_GEN_BURST_EN
        .burst    (burst),
`endif
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   ecount = 0;
    bit   op = 1'b0;
    int   acc, md, mw, mg, mn;
    logic mpol;
    logic idle_out = 1'b0;
    logic eo, eb, ed;

    // Operation length: delay, N periods of (width + gap), then the done cycle.
    function automatic int tdone();
        return md + mn * (mw + mg) + 1;
    endfunction

    function automatic bit in_pulse(int j);
        int jj;
        if (j < md + 1) return 1'b0;
        jj = j - md - 1;
        if (jj >= mn * (mw + mg)) return 1'b0;
        return (jj % (mw + mg)) < mw;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, ecount);
        end
    endtask

    task automatic model_edge();
        bit busy_before;
        int j;
        ecount++;
        busy_before = op && ((ecount - 1 - acc) < tdone());
        if (!busy_before) begin
            idle_out = ~edge_sel;
            op = 1'b0;
            if (start) begin
                op   = 1'b1;
                acc  = ecount;
                md   = int'(delay);
                mw   = (width == 0) ? 1 : int'(width);
                mg   = int'(gap);
                mpol = edge_sel;
`ifdef TRIGGER_PULSE_GEN_BURST_EN
                mn   = (burst == 0) ? 1 : int'(burst);
`else
                mn   = 1;
`endif
            end
        end
        if (op) begin
            j = ecount - acc;
            if (j < tdone()) begin
                eo = in_pulse(j) ? mpol : ~mpol;
                eb = 1'b1;
                ed = 1'b0;
            end else begin
                eo = ~mpol;
                eb = 1'b0;
                ed = 1'b1;
            end
        end else begin
            eo = idle_out;
            eb = 1'b0;
            ed = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("out", out, eo);
        check("busy", busy, eb);
        check("done", done, ed);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic launch(input logic es, input int d, input int w, input int g, input int b);
        edge_sel = es;
        delay    = CNT_W'(d);
        width    = CNT_W'(w);
        gap      = CNT_W'(g);
        burst    = CNT_W'(b);
        start    = 1'b1;
        cycle();
        start    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        edge_sel = 1'b1;
        delay    = '0;
        width    = '0;
        gap      = '0;
        burst    = 8'd1;
        #1;
        check("rst_out", out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run(2);

        // minimum pulse: D=0, W=1, G=0
        launch(1'b1, 0, 1, 0, 1);
        run(4);

        // negedge-leading pulse with delay and hold-off
        launch(1'b0, 3, 5, 2, 1);
        run(14);

        // width 0, start held high through busy and done, inputs changing mid-operation
        edge_sel = 1'b1;
        delay    = 8'd1;
        width    = 8'd0;
        gap      = 8'd1;
        burst    = 8'd1;
        start    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            edge_sel = ~edge_sel;
            width    = CNT_W'($urandom_range(0, 3));
            delay    = CNT_W'($urandom_range(0, 2));
            gap      = CNT_W'($urandom_range(0, 2));
        end
        start = 1'b0;
        run(16);

        // asynchronous reset while the pulse is active; start during reset is ignored
        launch(1'b1, 2, 6, 1, 1);
        run(4);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out", out, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rststart_busy", busy, 1'b0);
        check("rststart_out", out, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        run(3);

`ifdef TRIGGER_PULSE_GEN_BURST_EN
        // burst train: 3 pulses, D=1 W=2 G=1
        launch(1'b1, 1, 2, 1, 3);
        run(13);
        launch(1'b0, 0, 1, 0, 4);
        run(8);
`endif

        // all-ones counters must not wrap
        launch(1'b1, 255, 255, 255, 1);
        run(770);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            edge_sel = 1'($urandom);
            delay    = CNT_W'($urandom_range(0, 5));
            width    = CNT_W'($urandom_range(0, 5));
            gap      = CNT_W'($urandom_range(0, 3));
            burst    = CNT_W'($urandom_range(0, 3));
            cycle();
        end
        start = 1'b0;
        run(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
